// File: rtl/uart_rx_os_if.sv
// Receiver-to-consumer handshake bundle: held character, status flags and ack.
interface uart_rx_os_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       parity_err;
  logic       frame_err;
  logic       break_int;
  logic       overrun_err;
  logic       rx_busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_int, overrun_err, rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_int, overrun_err, rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, start-glitch
// rejection, parity (even/odd/stick), break detection and a held output
// register with ack handshake and sticky overrun.
module uart_rx_os #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_os,
  input  logic        srx,
  input  logic [7:0]  lcr,
  uart_rx_os_if.master rx
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] M_LO    = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] M_MID   = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] M_HI    = OSW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [7:0] d, input logic eps, input logic stick);
    if (stick)    return ~eps;
    else if (eps) return ^d;
    else          return ~(^d);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srx_s;

  state_t         state_q, state_d;
  logic [OSW-1:0] os_q, os_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           s0_q, s0_d, s1_q, s1_d;
  logic           zero_q, zero_d;
  logic           par_q, par_d;
  logic [1:0]     wl_q, wl_d;
  logic           pen_q, pen_d, eps_q, eps_d, stick_q, stick_d;

  logic           maj_now;
  logic [2:0]     wl_m1;
  logic [OSW-1:0] os_inc;
  logic           comp, frm_c, brk_c;
  logic           ovr_set, ack_take;
  logic           unused_lcr;

  assign srx_s      = sync_q[SYNC_STAGES-1];
  assign maj_now    = maj3(s0_q, s1_q, srx_s);
  assign wl_m1      = {1'b0, wl_q} + 3'd4;
  assign os_inc     = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
  assign unused_lcr = ^{lcr[7:6], lcr[2]};
  assign rx.rx_busy = (state_q != IDLE);

  // Input synchronizer: srx is asynchronous, idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], srx};
  end

  // FSM and per-character datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      zero_q  <= 1'b0;
      par_q   <= 1'b0;
      wl_q    <= '0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      stick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      wl_q    <= wl_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      stick_q <= stick_d;
    end
  end

  // Next-state logic: everything advances only on oversample ticks.
  // Bit decisions are made at M+1, when the third sample is on srx_s.
  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    zero_d  = zero_q;
    par_d   = par_q;
    wl_d    = wl_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    stick_d = stick_q;
    comp    = 1'b0;
    frm_c   = 1'b0;
    brk_c   = 1'b0;

    if (tick_os) begin
      if (state_q != IDLE && state_q != BRK_WAIT) begin
        os_d = os_inc;
        if (os_q == M_LO)  s0_d = srx_s;
        if (os_q == M_MID) s1_d = srx_s;
      end

      case (state_q)
        IDLE: begin
          if (!srx_s) begin
            // Character format is frozen here for the whole frame.
            state_d = START;
            os_d    = '0;
            bit_d   = '0;
            shift_d = '0;
            zero_d  = 1'b1;
            par_d   = 1'b0;
            wl_d    = lcr[1:0];
            pen_d   = lcr[3];
            eps_d   = lcr[4];
            stick_d = lcr[5];
          end
        end
        START: begin
          if (os_q == M_HI && maj_now) begin
            state_d = IDLE;
            os_d    = '0;
          end else if (os_q == OS_LAST) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (os_q == M_HI) begin
            shift_d[bit_q] = maj_now;
            zero_d         = zero_q & ~maj_now;
          end
          if (os_q == OS_LAST) begin
            if (bit_q == wl_m1) state_d = pen_q ? PARITY : STOP;
            else                bit_d   = bit_q + 3'd1;
          end
        end
        PARITY: begin
          if (os_q == M_HI) begin
            par_d  = (maj_now != exp_parity(shift_q, eps_q, stick_q));
            zero_d = zero_q & ~maj_now;
          end
          if (os_q == OS_LAST) state_d = STOP;
        end
        STOP: begin
          if (os_q == M_HI) begin
            comp    = 1'b1;
            frm_c   = ~maj_now;
            brk_c   = zero_q & ~maj_now;
            state_d = brk_c ? BRK_WAIT : IDLE;
            os_d    = '0;
          end
        end
        BRK_WAIT: begin
          os_d = '0;
          if (srx_s) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          os_d    = '0;
        end
      endcase
    end
  end

  assign ovr_set  = comp & rx.rx_valid & ~rx.rx_ack;
  assign ack_take = rx.rx_valid & rx.rx_ack;

  // Held output register, ack handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.rx_data     <= '0;
      rx.rx_valid    <= 1'b0;
      rx.parity_err  <= 1'b0;
      rx.frame_err   <= 1'b0;
      rx.break_int   <= 1'b0;
      rx.overrun_err <= 1'b0;
    end else begin
      if (comp && (!rx.rx_valid || rx.rx_ack)) begin
        rx.rx_data    <= brk_c ? 8'h00 : shift_q;
        rx.parity_err <= par_q;
        rx.frame_err  <= frm_c;
        rx.break_int  <= brk_c;
        rx.rx_valid   <= 1'b1;
      end else if (ack_take) begin
        rx.rx_valid   <= 1'b0;
      end
      if (ovr_set)       rx.overrun_err <= 1'b1;
      else if (ack_take) rx.overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, 7E1, stick parity, glitch, break,
// overrun and mid-character lcr change.
module tb_uart_rx_os;

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

  logic       clk;
  logic       rst_n;
  logic       tick_os;
  logic       srx;
  logic [7:0] lcr;
  int         total;
  int         bad;

  uart_rx_os_if rx_if ();

  uart_rx_os #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_os (tick_os),
    .srx     (srx),
    .lcr     (lcr),
    .rx      (rx_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_os = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_os = 1'b1;
      @(negedge clk);
      tick_os = 1'b0;
    end
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    srx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen, input logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(1'b1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_if.rx_ack = 1'b1;
    @(negedge clk);
    rx_if.rx_ack = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    srx   = 1'b1;
    lcr   = 8'h03;
    rx_if.rx_ack = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    chk1("rst_valid", rx_if.rx_valid, 1'b0);
    chk8("rst_data", rx_if.rx_data, 8'h00);
    chk1("rst_busy", rx_if.rx_busy, 1'b0);
    chk1("rst_overrun", rx_if.overrun_err, 1'b0);
    chk1("rst_break", rx_if.break_int, 1'b0);
    rst_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0);
    send_bit(1'b1);
    chk1("a5_valid", rx_if.rx_valid, 1'b1);
    chk8("a5_data", rx_if.rx_data, 8'hA5);
    chk1("a5_parity", rx_if.parity_err, 1'b0);
    chk1("a5_frame", rx_if.frame_err, 1'b0);
    chk1("a5_break", rx_if.break_int, 1'b0);
    chk1("a5_busy", rx_if.rx_busy, 1'b0);
    do_ack();
    chk1("a5_ack_valid", rx_if.rx_valid, 1'b0);
    chk8("a5_ack_data_hold", rx_if.rx_data, 8'hA5);

    // 7E1 0x35 with wrong then right parity
    lcr = 8'h1A;
    send_frame(8'h35, 7, 1'b1, 1'b1);
    send_bit(1'b1);
    chk1("7e1_bad_valid", rx_if.rx_valid, 1'b1);
    chk8("7e1_bad_data", rx_if.rx_data, 8'h35);
    chk1("7e1_bad_parity", rx_if.parity_err, 1'b1);
    chk1("7e1_bad_frame", rx_if.frame_err, 1'b0);
    do_ack();
    chk1("7e1_ack_parity_hold", rx_if.parity_err, 1'b1);
    send_frame(8'h35, 7, 1'b1, 1'b0);
    send_bit(1'b1);
    chk8("7e1_ok_data", rx_if.rx_data, 8'h35);
    chk1("7e1_ok_parity", rx_if.parity_err, 1'b0);
    do_ack();

    // Start glitch: 5 ticks low
    lcr = 8'h03;
    srx = 1'b0;
    repeat (20) @(negedge clk);
    chk1("glitch_busy_on", rx_if.rx_busy, 1'b1);
    srx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    chk1("glitch_busy_off", rx_if.rx_busy, 1'b0);
    chk1("glitch_valid", rx_if.rx_valid, 1'b0);

    // Break: 12 bit times low
    srx = 1'b0;
    repeat (12 * BIT_CLK) @(negedge clk);
    chk1("brk_valid", rx_if.rx_valid, 1'b1);
    chk8("brk_data", rx_if.rx_data, 8'h00);
    chk1("brk_break", rx_if.break_int, 1'b1);
    chk1("brk_frame", rx_if.frame_err, 1'b1);
    do_ack();
    repeat (2 * BIT_CLK) @(negedge clk);
    chk1("brk_no_second", rx_if.rx_valid, 1'b0);
    chk1("brk_wait_busy", rx_if.rx_busy, 1'b1);
    send_bit(1'b1);
    chk1("brk_release_busy", rx_if.rx_busy, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0);
    send_bit(1'b1);
    chk1("post_brk_valid", rx_if.rx_valid, 1'b1);
    chk8("post_brk_data", rx_if.rx_data, 8'h5A);
    chk1("post_brk_break", rx_if.break_int, 1'b0);
    chk1("post_brk_frame", rx_if.frame_err, 1'b0);
    do_ack();

    // Back-to-back frames without ack -> overrun
    send_frame(8'h11, 8, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0);
    send_bit(1'b1);
    chk1("ovr_valid", rx_if.rx_valid, 1'b1);
    chk8("ovr_data", rx_if.rx_data, 8'h11);
    chk1("ovr_flag", rx_if.overrun_err, 1'b1);
    do_ack();
    chk1("ovr_ack_valid", rx_if.rx_valid, 1'b0);
    chk1("ovr_ack_flag", rx_if.overrun_err, 1'b0);

    // 5-bit stick parity, lcr changed mid-character
    lcr = 8'h38;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) lcr = 8'h03;
      send_bit(1'b1);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk1("stick_valid", rx_if.rx_valid, 1'b1);
    chk8("stick_data", rx_if.rx_data, 8'h1F);
    chk1("stick_parity", rx_if.parity_err, 1'b0);
    chk1("stick_frame", rx_if.frame_err, 1'b0);
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised UART receiver: next generation of the 16550-compatible RX path.
- Adds configurable oversampling, 3-sample majority voting, start-glitch rejection and real parity checking (even/odd/stick).
- Adds break detection, a held output register with ack handshake and overrun detection.
- Sits between the baud generator (oversample tick) and the RX FIFO/LSR logic; character format comes from LCR.

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit; even, 8..16.
- SYNC_STAGES, 2, srx synchronizer depth; >=2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- tick_os  in  1  oversample enable, 1-clk pulse, OVERSAMPLE per bit time
- srx  in  1  serial input, idle high, asynchronous
- lcr  in  8  [1:0] word length 5..8, [3] PEN, [4] EPS, [5] stick parity; other bits ignored
- rx_ack  in  1  consumer takes rx_data
- rx_data  out  8  received character, unused high bits 0
- rx_valid  out  1  rx_data holds an unconsumed character
- parity_err  out  1  status of the held character
- frame_err  out  1  status of the held character
- break_int  out  1  held character was a break
- overrun_err  out  1  sticky: a character was lost
- rx_busy  out  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low: synchronizer flops=1, state=IDLE, counters=0, all outputs 0.
- srx passes through SYNC_STAGES flops; srx_s is the last stage. All logic below acts only on cycles with tick_os=1, except the output handshake.
- os_cnt counts 0..OVERSAMPLE-1 within a bit.
- Samples are taken at os_cnt = M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three.
- States:
  - IDLE: on tick with srx_s=0 -> START, os_cnt=0. At the same point, latch lcr into an internal copy. lcr changes mid-character have no effect.
  - START: if the majority is 1 at os_cnt=M+1 -> IDLE. This is a glitch: no flags, no output. Else at os_cnt=OVERSAMPLE-1 -> DATA, bit_cnt=0, os_cnt=0.
  - DATA: the majority bit is written to shift[bit_cnt], LSB first. At os_cnt=OVERSAMPLE-1:
    - if bit_cnt = word_len-1 -> PARITY (PEN=1) or STOP (PEN=0);
    - else bit_cnt+1.
  - PARITY: expected bit =
    - stick=1: ~EPS;
    - EPS=1: XOR of data bits;
    - EPS=0: ~XOR.
    A mismatch sets the parity flag for this character. At period end -> STOP.
  - STOP: only the first stop bit is checked; lcr[2] is ignored. At os_cnt=M+1 the character completes and the state goes to IDLE, so a start edge half a bit later is caught.
    - frame flag = stop majority is 0.
    - break flag = all sampled bits (data, parity, stop) were 0. A break forces frame flag=1 and data 0x00.
    - After a break -> BRK_WAIT. Stay there until a tick with srx_s=1, then -> IDLE.
- Completion (one clk after the completing tick):
  - rx_valid=0 or rx_ack=1 same cycle: load rx_data/parity_err/frame_err/break_int; rx_valid=1.
  - rx_valid=1 and rx_ack=0: character discarded, held data and flags unchanged, overrun_err=1.
- rx_ack with rx_valid=1 and no completion: rx_valid=0 next clk; flags hold until the next load.
- rx_ack clears overrun_err unless an overrun occurs in the same cycle; the set wins.
- rx_ack with rx_valid=0: no effect.
- Latency: rx_valid rises 1 clk after the tick at os_cnt=M+1 of the stop bit.
- rst_n asserted mid-character: immediate return to reset state; the partial character is lost.

Test Plan:
- 8N1 (lcr=0x03), OVERSAMPLE=16, tick every 4 clk, send 0xA5 -> rx_data=0xA5, rx_valid=1, parity/frame/break=0, rx_busy=0 after completion.
- 7E1 (lcr=0x1A) send 0x35 with parity bit 1 -> rx_data=0x35, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- srx low for 5 ticks then high -> no rx_valid, no flags, rx_busy back to 0 within one bit time.
- srx low for 12 bit times then high (8N1) -> one character: rx_data=0x00, break_int=1, frame_err=1. No second character until srx high, then a normal 0x5A is received correctly.
- Two back-to-back 8N1 frames (0x11, 0x22), no rx_ack -> rx_data=0x11, overrun_err=1. rx_ack -> rx_valid=0, overrun_err=0.
- 5-bit stick parity (lcr=0x38) send 0x1F with parity bit 0 -> parity_err=0. Change lcr to 0x03 mid-character -> the character is still decoded as 5-bit, rx_data=0x1F.
